// File: rtl/iq_dac_pkg.sv
// Shared types and constants for the I/Q DAC serializer: FSM states, SPI command
// nibbles, frame geometry and the offset-binary conversion mask.
package iq_dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B,
    LDAC
  } state_t;

  localparam logic [3:0] CMD_A   = 4'b0001;
  localparam logic [3:0] CMD_B   = 4'b0010;
  localparam int         FRAME_W = 16;
  localparam int         GAP_HP  = 2;
  localparam int         LDAC_HP = 2;
  localparam logic [7:0] OB_MASK = 8'h80;

  // DAC word layout: command nibble, data byte, four don't-care zeros.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] cmd,
                                                    input logic [7:0] data);
    return {cmd, data, 4'b0000};
  endfunction

endpackage

// File: rtl/iq_dac_serializer_sclk_tick_gen.sv
// Divider that emits a one-cycle tick every CLK_DIV cycles; held at zero while
// clear is high so each SHIFT state starts from a known phase.
module sclk_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == LAST);

  // NOTE: every path assigns cnt_d (default first), so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iq_dac_serializer.sv
// Converts signed I/Q sample pairs to offset binary, buffers one pair, and ships
// them as two 16-bit SPI frames to a dual DAC followed by a shared LDAC pulse.
module iq_dac_serializer
  import iq_dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sin_in,
  input  logic [7:0] cos_in,
  output logic       sample_ready,
  input  logic       clear_overrun,
  output logic       overrun,
  output logic       busy,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       dac_cs_n,
  output logic       dac_ldac_n
);

  localparam int            HW        = $clog2(((GAP_HP > LDAC_HP) ? GAP_HP : LDAC_HP) * CLK_DIV + 1);
  localparam logic [HW-1:0] GAP_LAST  = HW'(GAP_HP * CLK_DIV - 1);
  localparam logic [HW-1:0] LDAC_LAST = HW'(LDAC_HP * CLK_DIV - 1);
  localparam int            BW        = $clog2(FRAME_W);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);

  state_t             state_q;
  logic               hold_full_q, hold_full_d;
  logic [15:0]        hold_q, hold_d;
  logic               overrun_q, overrun_d;
  logic [FRAME_W-1:0] sh_a_q, sh_b_q;
  logic [BW-1:0]      bit_cnt_q;
  logic [HW-1:0]      hp_cnt_q;
  logic               sclk_q, mosi_q, cs_n_q, ldac_n_q;
  logic               tick, in_shift, load;
  logic [FRAME_W-1:0] frame_a, frame_b;

  assign in_shift = (state_q == SHIFT_A) || (state_q == SHIFT_B);
  assign load     = (state_q == IDLE) && hold_full_q;
  assign frame_a  = make_frame(CMD_A, hold_q[15:8]);
  assign frame_b  = make_frame(CMD_B, hold_q[7:0]);

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(!in_shift),
    .tick (tick)
  );

  // Accept and load are mutually exclusive: one needs hold empty, the other full.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    overrun_d   = overrun_q;
    if (load) hold_full_d = 1'b0;
    if (sample_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = {sin_in ^ OB_MASK, cos_in ^ OB_MASK};
    end
    if (clear_overrun)               overrun_d = 1'b0;
    if (sample_valid && hold_full_q) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      bit_cnt_q <= '0;
      hp_cnt_q  <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ldac_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (hold_full_q) begin
          sh_a_q    <= frame_a;
          sh_b_q    <= frame_b;
          mosi_q    <= frame_a[FRAME_W-1];
          cs_n_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT_A;
        end
        SHIFT_A, SHIFT_B: if (tick) begin
          sclk_q <= !sclk_q;
          // Falling tick: present the next bit; the 16th one closes the frame.
          if (sclk_q) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (state_q == SHIFT_A) begin
              sh_a_q <= {sh_a_q[FRAME_W-2:0], 1'b0};
              mosi_q <= sh_a_q[FRAME_W-2];
            end else begin
              sh_b_q <= {sh_b_q[FRAME_W-2:0], 1'b0};
              mosi_q <= sh_b_q[FRAME_W-2];
            end
            if (bit_cnt_q == BIT_LAST) begin
              cs_n_q   <= 1'b1;
              hp_cnt_q <= '0;
              state_q  <= (state_q == SHIFT_A) ? GAP_A : GAP_B;
            end
          end
        end
        GAP_A: begin
          hp_cnt_q <= hp_cnt_q + 1'b1;
          if (hp_cnt_q == GAP_LAST) begin
            hp_cnt_q  <= '0;
            mosi_q    <= sh_b_q[FRAME_W-1];
            cs_n_q    <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT_B;
          end
        end
        GAP_B: begin
          hp_cnt_q <= hp_cnt_q + 1'b1;
          if (hp_cnt_q == GAP_LAST) begin
            hp_cnt_q <= '0;
            ldac_n_q <= 1'b0;
            state_q  <= LDAC;
          end
        end
        LDAC: begin
          hp_cnt_q <= hp_cnt_q + 1'b1;
          if (hp_cnt_q == LDAC_LAST) begin
            hp_cnt_q <= '0;
            ldac_n_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = !hold_full_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_ldac_n   = ldac_n_q;

endmodule

// File: tb/tb_iq_dac_serializer.sv
// Scoreboard bench: a transaction-level model predicts each accepted pair's frames
// and start cycle; per-DUT monitors decode the SPI bus and compare on each LDAC.
module tb_iq_dac_serializer;

  typedef struct {
    logic [15:0] fa;
    logic [15:0] fb;
    int          start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] sin_in = 8'h00;
  logic [7:0] cos_in = 8'h00;
  logic [1:0] ready_w, ov_w, busy_w, sclk_w, mosi_w, cs_n_w, ldac_n_w;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   divs [2] = '{2, 1};
  exp_t q0[$];
  exp_t q1[$];
  bit   has_hold [2];
  bit   ov_m [2];
  int   acc [2];
  int   p_ld [2];
  int   p_end [2];
  int   c_ld [2];
  int   c_end [2];
  int   ldac_falls [2];

  always #5 clk = ~clk;

  iq_dac_serializer #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sin_in(sin_in), .cos_in(cos_in),
    .sample_ready(ready_w[0]), .clear_overrun(clear_overrun), .overrun(ov_w[0]), .busy(busy_w[0]),
    .dac_sclk(sclk_w[0]), .dac_mosi(mosi_w[0]), .dac_cs_n(cs_n_w[0]), .dac_ldac_n(ldac_n_w[0])
  );

  iq_dac_serializer #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sin_in(sin_in), .cos_in(cos_in),
    .sample_ready(ready_w[1]), .clear_overrun(clear_overrun), .overrun(ov_w[1]), .busy(busy_w[1]),
    .dac_sclk(sclk_w[1]), .dac_mosi(mosi_w[1]), .dac_cs_n(cs_n_w[1]), .dac_ldac_n(ldac_n_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_span(input int n, input int a, input int b);
    return (n >= a) && (n < b);
  endfunction

  // Reference model: one holding slot, a transfer of 70*D cycles, and the load
  // happening on the edge after both the sample and an idle FSM are available.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        has_hold[i] = 1'b0;
        ov_m[i]     = 1'b0;
        p_ld[i] = 0; p_end[i] = 0; c_ld[i] = 0; c_end[i] = 0;
      end else begin
        bit   full;
        int   l;
        exp_t e;
        full = has_hold[i] && (acc[i] < cyc) && (cyc <= c_ld[i]);
        if (sample_valid && full) ov_m[i] = 1'b1;
        else if (clear_overrun)   ov_m[i] = 1'b0;
        if (sample_valid && !full) begin
          l = (c_end[i] + 1 > cyc + 1) ? c_end[i] + 1 : cyc + 1;
          p_ld[i]  = c_ld[i];
          p_end[i] = c_end[i];
          c_ld[i]  = l;
          c_end[i] = l + 70 * divs[i];
          acc[i]   = cyc;
          has_hold[i] = 1'b1;
          e.fa    = {4'h1, 8'(sin_in + 8'd128), 4'h0};
          e.fb    = {4'h2, 8'(cos_in + 8'd128), 4'h0};
          e.start = l;
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
    if (reset) begin
      q0.delete();
      q1.delete();
    end
  end

  task automatic monitor(input int i);
    int          d = divs[i];
    logic        ps = 1'b0, pc = 1'b1, pl = 1'b1;
    logic        s, m, c, l;
    int          nbits = 0, nfr = 0, cs_fall = 0, l_fall = 0;
    logic [15:0] sh = '0, fr0 = '0, fr1 = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        ps = 1'b0; pc = 1'b1; pl = 1'b1; nbits = 0; nfr = 0;
        continue;
      end
      s = sclk_w[i]; m = mosi_w[i]; c = cs_n_w[i]; l = ldac_n_w[i];
      check($sformatf("ready_d%0d", d), 32'(ready_w[i]),
            32'(!(has_hold[i] && acc[i] <= cyc && cyc < c_ld[i])));
      check($sformatf("overrun_d%0d", d), 32'(ov_w[i]), 32'(ov_m[i]));
      check($sformatf("busy_d%0d", d), 32'(busy_w[i]),
            32'(in_span(cyc, p_ld[i], p_end[i]) || in_span(cyc, c_ld[i], c_end[i])));
      if (!ps && s && !c) begin
        sh = {sh[14:0], m};
        nbits++;
      end
      if (pc && !c) begin
        nbits = 0;
        if (nfr == 0) cs_fall = cyc;
      end
      if (!pc && c) begin
        check($sformatf("sclk_at_cs_rise_d%0d", d), 32'(s), 32'(0));
        check($sformatf("bits_per_frame_d%0d", d), 32'(nbits), 32'd16);
        if (nfr == 0) fr0 = sh;
        else          fr1 = sh;
        nfr++;
      end
      if (pl && !l) begin
        l_fall = cyc;
        ldac_falls[i]++;
      end
      if (!pl && l) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          check($sformatf("unexpected_ldac_d%0d", d), 32'(1), 32'(0));
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("frame_count_d%0d", d), 32'(nfr), 32'd2);
          check($sformatf("frame_a_d%0d", d), 32'(fr0), 32'(e.fa));
          check($sformatf("frame_b_d%0d", d), 32'(fr1), 32'(e.fb));
          check($sformatf("cs_fall_cycle_d%0d", d), 32'(cs_fall), 32'(e.start));
          check($sformatf("ldac_low_len_d%0d", d), 32'(cyc - l_fall), 32'(2 * d));
          check($sformatf("txn_len_d%0d", d), 32'(cyc - cs_fall), 32'(70 * d));
        end
        nfr = 0;
      end
      ps = s; pc = c; pl = l;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] s, input logic [7:0] c, input logic clr);
    @(negedge clk);
    sample_valid  = 1'b1;
    sin_in        = s;
    cos_in        = c;
    clear_overrun = clr;
    @(negedge clk);
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_cs_n"},   32'(cs_n_w[i]),   32'(1));
      check({tag, "_ldac_n"}, 32'(ldac_n_w[i]), 32'(1));
      check({tag, "_sclk"},   32'(sclk_w[i]),   32'(0));
      check({tag, "_mosi"},   32'(mosi_w[i]),   32'(0));
      check({tag, "_ready"},  32'(ready_w[i]),  32'(1));
      check({tag, "_busy"},   32'(busy_w[i]),   32'(0));
      check({tag, "_ovr"},    32'(ov_w[i]),     32'(0));
    end
  endtask

  initial begin
    int lf0, lf1;
    fork
      monitor(0);
      monitor(1);
    join_none
    idle(3);
    check_reset_outputs("por");
    #2 reset = 1'b0;
    idle(3);

    // Full-scale and zero/negative mapping.
    strobe(8'h7F, 8'h80, 1'b0); idle(200);
    strobe(8'h00, 8'hFF, 1'b0); idle(200);

    // Second pair 20 cycles after the first: buffered, sent right after LDAC.
    strobe(8'h12, 8'hE4, 1'b0); idle(18);
    strobe(8'hC3, 8'h3C, 1'b0); idle(400);

    // Three strobes inside one transfer: the third is dropped.
    strobe(8'h01, 8'h02, 1'b0); idle(10);
    strobe(8'h81, 8'h7E, 1'b0); idle(10);
    strobe(8'h55, 8'h66, 1'b0);
    check("overrun_after_drop", 32'(ov_w[0]), 32'(1));
    idle(3);
    strobe(8'h77, 8'h88, 1'b1);
    check("overrun_clear_vs_set", 32'(ov_w[0]), 32'(1));
    idle(3);
    @(negedge clk) clear_overrun = 1'b1;
    @(negedge clk) clear_overrun = 1'b0;
    check("overrun_clear_alone", 32'(ov_w[0]), 32'(0));
    idle(400);

    for (int k = 0; k < 24; k++) begin
      strobe(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 180));
    end
    idle(400);

    // Asynchronous reset in the middle of frame A.
    strobe(8'h5A, 8'hA5, 1'b0); idle(20);
    lf0 = ldac_falls[0];
    lf1 = ldac_falls[1];
    check("mid_frame_cs_active", 32'(cs_n_w[0]), 32'(0));
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    idle(3);
    #2 reset = 1'b0;
    idle(300);
    check("no_ldac_after_reset_d2", 32'(ldac_falls[0]), 32'(lf0));
    check("no_ldac_after_reset_d1", 32'(ldac_falls[1]), 32'(lf1));
    check("scoreboard_drained_d2", 32'(q0.size()), 32'(0));
    check("scoreboard_drained_d1", 32'(q1.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
